// File: rtl/gate_truth_table_checker.sv
// ---------------------------------------------------------------------------
// gate_truth_table_checker
//
// Self-test engine for a two-input logic gate. It applies the four input
// vectors 00, 01, 10, 11 to the gate (in1/in2). For each vector it waits
// SETTLE_CYCLES cycles and then compares gate_out with the truth table of
// the function latched from gate_sel. The result of a run is reported as a
// pass flag, a saturating error count and a per-vector failure map.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, honoured only while idle
//   gate_sel   in   [2:0] 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR,
//                   6 NOT(in1), 7 BUF(in1)
//   gate_out   in   output of the gate under test (synchronous to clk)
//   in1, in2   out  registered stimulus to the gate
//   busy       out  high while vectors are being applied
//   done       out  one-cycle pulse at the end of a run
//   pass       out  last run had no mismatches
//   err_count  out  [ERR_W-1:0] saturating mismatch count of the last run
//   fail_vec   out  [3:0] bit i set when vector i = {in1,in2} mismatched
// ---------------------------------------------------------------------------
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             gate_out,
  output logic             in1,
  output logic             in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  // A settle count of zero still needs a legal one-bit counter.
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel_q;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;

  function automatic logic expected_out(input logic [2:0] sel,
                                        input logic a,
                                        input logic b);
    logic y;
    case (sel)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~(a & b);
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    return v + ERR_W'(1);
  endfunction

  always_comb begin
    mismatch = (gate_out != expected_out(sel_q, in1, in2));
    err_nxt  = sat_inc(err_count);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (cnt == CNT_W'(1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DRIVE, SETTLE, SAMPLE: busy = 1'b1;
      DONE:                  done = 1'b1;
      default:               ;
    endcase
  end

  // Stimulus, settle counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1       <= 1'b0;
      in2       <= 1'b0;
      idx       <= 2'd0;
      cnt       <= '0;
      sel_q     <= 3'd0;
      err_count <= '0;
      fail_vec  <= 4'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_q      <= gate_sel;
            idx        <= 2'd0;
            err_count  <= '0;
            fail_vec   <= 4'd0;
            pass       <= 1'b0;
            {in1, in2} <= 2'b00;
          end
        end
        DRIVE:  cnt <= CNT_W'(SETTLE_CYCLES);
        SETTLE: cnt <= cnt - CNT_W'(1);
        SAMPLE: begin
          if (mismatch) begin
            fail_vec  <= fail_vec | (4'b0001 << idx);
            err_count <= err_nxt;
          end
          if (idx == 2'd3) begin
            // The count saturates and never wraps back to zero, so the
            // run passes only if this last vector and all earlier ones matched.
            pass <= !mismatch && (err_count == '0);
          end else begin
            idx        <= idx + 2'd1;
            {in1, in2} <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

  logic       clk;
  logic       rst_n;

  // Instance A: default parameters (SETTLE_CYCLES=2, ERR_W=3)
  logic       start_a, gate_out_a, in1_a, in2_a, busy_a, done_a, pass_a;
  logic [2:0] sel_a, err_a;
  logic [3:0] fail_a, tt_a;

  // Instance B: SETTLE_CYCLES=0, ERR_W=2
  logic       start_b, gate_out_b, in1_b, in2_b, busy_b, done_b, pass_b;
  logic [2:0] sel_b;
  logic [1:0] err_b;
  logic [3:0] fail_b, tt_b;

  int n_vec  = 0;
  int n_miss = 0;

  gate_truth_table_checker dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .gate_sel(sel_a),
    .gate_out(gate_out_a), .in1(in1_a), .in2(in2_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fail_a)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(0), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .gate_sel(sel_b),
    .gate_out(gate_out_b), .in1(in1_b), .in2(in2_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fail_b)
  );

  // Gate under test, described by its truth table (bit i = output for {in1,in2}=i)
  assign gate_out_a = tt_a[{in1_a, in2_a}];
  assign gate_out_b = tt_b[{in1_b, in2_b}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Truth table of the selected function, bit i for vector i = {in1,in2}
  function automatic logic [3:0] ref_tt(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get(input int w, output logic b, output logic d, output logic [1:0] v,
                     output logic p, output logic [2:0] e, output logic [3:0] f);
    if (w == 0) begin
      b = busy_a; d = done_a; v = {in1_a, in2_a}; p = pass_a; e = err_a; f = fail_a;
    end else begin
      b = busy_b; d = done_b; v = {in1_b, in2_b}; p = pass_b; e = {1'b0, err_b}; f = fail_b;
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [2:0] sl);
    if (w == 0) begin start_a = st; sel_a = sl; end
    else        begin start_b = st; sel_b = sl; end
  endtask

  // One run: gate truth table tt_gate, function sel. perturb pulses start and
  // flips gate_sel mid-run; rst_at > 0 asserts reset in that cycle and ends the run.
  task automatic run(input int w, input logic [2:0] sel, input logic [3:0] tt_gate,
                     input bit perturb, input int rst_at);
    int per, maxe, ne, dcyc;
    logic b, d, p;
    logic [1:0] v;
    logic [2:0] e;
    logic [3:0] f, exp_f;
    per  = (w == 0) ? 4 : 2;
    maxe = (w == 0) ? 7 : 3;
    @(negedge clk);
    if (w == 0) tt_a = tt_gate; else tt_b = tt_gate;
    drive(w, 1'b1, sel);
    @(posedge clk);
    dcyc = -1;
    for (int c = 1; c <= 4 * per + 4; c++) begin
      @(negedge clk);
      if (c == 1) drive(w, 1'b0, sel);
      if (perturb && c == per + 2) drive(w, 1'b1, ~sel);
      if (perturb && c == per + 3) drive(w, 1'b0, ~sel);
      get(w, b, d, v, p, e, f);
      if (c == rst_at) begin
        #1 rst_n = 1'b0;
        #1 get(w, b, d, v, p, e, f);
        chk("rst_mid_run", {24'd0, b, d, v, p, e}, 32'd0);
        chk("rst_fail_vec", {28'd0, f}, 32'd0);
        #1 rst_n = 1'b1;
        return;
      end
      if (d) begin dcyc = c; break; end
      chk("busy_run", {31'd0, b}, 32'd1);
      chk("stim_vec", {30'd0, v}, (c - 1) / per);
    end
    chk("done_cycle", dcyc, 4 * per + 1);
    if (dcyc > 0) begin
      exp_f = tt_gate ^ ref_tt(sel);
      ne = $countones(exp_f);
      if (ne > maxe) ne = maxe;
      chk("busy_done", {31'd0, b}, 32'd0);
      chk("fail_vec", {28'd0, f}, {28'd0, exp_f});
      chk("err_count", {29'd0, e}, ne);
      chk("pass", {31'd0, p}, {31'd0, (exp_f == 4'd0)});
      @(negedge clk);
      get(w, b, d, v, p, e, f);
      chk("done_pulse", {30'd0, b, d}, 32'd0);
      chk("hold_vec", {30'd0, v}, 32'd3);
      chk("hold_res", {24'd0, p, e, f}, {24'd0, (exp_f == 4'd0), ne[2:0], exp_f});
    end
  endtask

  initial begin
    logic b, d, p;
    logic [1:0] v;
    logic [2:0] e, sel;
    logic [3:0] f, mask;
    int w;
    rst_n = 1'b0;
    start_a = 1'b0; sel_a = 3'd0; tt_a = 4'd0;
    start_b = 1'b0; sel_b = 3'd0; tt_b = 4'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      get(i, b, d, v, p, e, f);
      chk("reset_state", {20'd0, b, d, v, p, e, f}, 32'd0);
    end
    rst_n = 1'b1;

    run(0, 3'd1, 4'b1110, 1'b0, 0);   // OR checked against a real OR gate
    run(0, 3'd0, 4'b1110, 1'b0, 0);   // AND checked against an OR gate
    run(0, 3'd3, 4'b1111, 1'b0, 0);   // NOR checked against stuck-at-1
    run(1, 3'd4, 4'b1001, 1'b0, 0);   // XOR against XNOR, no settle, 2-bit count
    run(0, 3'd1, 4'b1110, 1'b1, 0);   // start/sel changes mid-run ignored
    run(0, 3'd1, 4'b1110, 1'b0, 10);  // reset during settle of vector 2
    run(0, 3'd1, 4'b1110, 1'b0, 0);   // clean run after reset
    run(0, 3'd6, 4'b0011, 1'b0, 0);   // NOT ignores in2
    run(1, 3'd7, 4'b1100, 1'b0, 0);   // BUF ignores in2

    for (int r = 0; r < 16; r++) begin
      w    = $urandom_range(1, 0);
      sel  = 3'($urandom_range(7, 0));
      mask = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) mask = 4'd0;
      run(w, sel, ref_tt(sel) ^ mask, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
Self-checking stimulus engine for the two-input basic logic gates in this library. It drives the gate's in1/in2 inputs, samples the gate's out, and compares it with the expected value for the selected function over all four input combinations. It reports a pass/fail flag, an error count and a per-vector failure map. It is synthesizable and sits beside any gate module, for example in a board-level self-test.

Parameters:
SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling gate_out (0 allowed)
ERR_W, 3, width of err_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
gate_sel  input  3  function under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(in1), 7 BUF(in1)
gate_out  input  1  output of the gate under test
in1  output  1  stimulus to the gate's in1 (registered)
in2  output  1  stimulus to the gate's in2 (registered)
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at the end of a run
pass  output  1  1 when the last run had zero mismatches
err_count  output  ERR_W  mismatches in the last run, saturating
fail_vec  output  4  bit i set if vector i={in1,in2} mismatched

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous, immediate, legal mid-run):
  - state goes to IDLE;
  - in1, in2, busy, done, pass, err_count, fail_vec and the vector index all become 0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at a clock edge moves to DRIVE.
  - The same edge latches gate_sel, sets idx=0, and clears err_count, fail_vec and pass.
- DRIVE (1 cycle):
  - {in1,in2} = idx, registered on entry, so valid from the first DRIVE cycle.
  - The settle counter loads SETTLE_CYCLES.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (1 cycle):
  - gate_out is compared at the exiting edge with expected = f(latched sel, in1, in2).
  - On mismatch: fail_vec[idx] is set and err_count increments, saturating at 2^ERR_W-1.
  - If idx==3, go to DONE; otherwise idx increments and the FSM returns to DRIVE.
- DONE (1 cycle): done=1 and pass=(err_count==0), then return to IDLE.
- busy is 1 in DRIVE, SETTLE and SAMPLE; it is 0 in IDLE and DONE.
- Vector period is 2+SETTLE_CYCLES cycles. Vector order is 00, 01, 10, 11.
- Timing: if start is accepted at edge 0, done is high in cycle 4*(2+SETTLE_CYCLES)+1, which is cycle 17 for the default.
- Holding behaviour:
  - in1/in2 hold the last vector (11) after a run, until the next start or reset.
  - pass, err_count and fail_vec hold until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- gate_sel changes during a run are ignored; the latched value is used.
- NOT and BUF ignore in2, but all four vectors are still applied.
- gate_out is treated as synchronous to clk. Synchronizing an asynchronous source is outside this block.

Test Plan:
1. OR (sel=1), gate_out=in1|in2 from a real OR gate, default params:
   - in1/in2 step 00, 01, 10, 11, each held 4 cycles;
   - done in cycle 17; pass=1, err_count=0, fail_vec=0000.
2. sel=0 (AND) with gate_out driven by an OR gate -> err_count=2, fail_vec=0110, pass=0.
3. sel=3 (NOR) with gate_out stuck at 1 -> expected 1,0,0,0, so fail_vec=1110, err_count=3, pass=0.
4. SETTLE_CYCLES=0, ERR_W=2, sel=4 (XOR), gate_out=XNOR:
   - done in cycle 9;
   - err_count saturates at 3; fail_vec=1111.
5. sel=1 run; mid-run, start is pulsed again and gate_sel switches to 0 -> no restart, done still in cycle 17, pass=1 (OR checked).
6. rst_n pulsed low during SETTLE of vector 2:
   - all outputs are 0 immediately, before the next clock edge;
   - a following start performs a complete clean 4-vector run with correct results.
